// File: rtl/opq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opq_pkg
// Brief    : Opcodes, error codes and ring-index helper for param_op_queue.
// Revision : 1.0
// ============================================================================
package opq_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_NOP  = 2'b01,
        OP_COMB = 2'b10,
        OP_POP  = 2'b11
    } opcode_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_COMB = 2'b11;

    // step < depth and idx < depth, so one conditional subtract replaces a modulo.
    function automatic int unsigned wrap_add(input int unsigned idx,
                                             input int unsigned step,
                                             input int unsigned depth);
        int unsigned s;
        s = idx + step;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_op_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : param_op_queue_if
// Brief    : Request/status bundle of the operand queue. Macro OPQ_ERR_COUNT_EN
//            adds the err_cnt signal.
// Revision : 1.0
// ============================================================================
interface param_op_queue_if
    import opq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic                in_valid;
    opcode_e             opcode;
    logic [DATA_W-1:0]   din;
    logic                err_clr;
    logic                in_ready;
    logic [2*DATA_W-1:0] top_pair;
    logic [DATA_W-1:0]   tail;
    logic [CNT_W-1:0]    count;
    logic                empty;
    logic                full;
    logic                err;
    logic [1:0]          err_code;
`ifdef OPQ_ERR_COUNT_EN
    logic [7:0]          err_cnt;

    modport master (
        output in_valid, opcode, din, err_clr,
        input  in_ready, top_pair, tail, count, empty, full, err, err_code, err_cnt
    );
    modport slave (
        input  in_valid, opcode, din, err_clr,
        output in_ready, top_pair, tail, count, empty, full, err, err_code, err_cnt
    );
`else
    modport master (
        output in_valid, opcode, din, err_clr,
        input  in_ready, top_pair, tail, count, empty, full, err, err_code
    );
    modport slave (
        input  in_valid, opcode, din, err_clr,
        output in_ready, top_pair, tail, count, empty, full, err, err_code
    );
`endif
endinterface
`default_nettype wire

// File: rtl/opq_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module   : opq_ring_ptr
// Brief    : Ring index with +1 / +2 modulo-DEPTH advance (inc2 has priority).
// Revision : 1.0
// ============================================================================
module opq_ring_ptr
    import opq_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc1,
    input  wire logic             inc2,
    output logic      [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc2) begin
            ptr_d = PTR_W'(wrap_add(32'(ptr_q), 2, DEPTH));
        end else if (inc1) begin
            ptr_d = PTR_W'(wrap_add(32'(ptr_q), 1, DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/param_op_queue.sv
`default_nettype none
// ============================================================================
// Module   : param_op_queue
// Brief    : Ring-buffer operand queue with push/pop/combine and a sticky,
//            coded error. Macro OPQ_ERR_COUNT_EN adds a rejected-request counter.
// Revision : 1.0
// ============================================================================
module param_op_queue
    import opq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    param_op_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_OK  = 1'b0,
        ST_ERR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  wr;
    logic [PTR_W-1:0]  head_nxt;
    logic [PTR_W-1:0]  wr_prev;

    logic accept;
    logic has1, has2, is_full;
    logic do_push, do_pop, do_comb;

    assign has1     = (count_q != '0);
    assign has2     = (count_q >= CNT_W'(2));
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign head_nxt = PTR_W'(wrap_add(32'(head), 1, DEPTH));
    assign wr_prev  = PTR_W'(wrap_add(32'(wr), DEPTH - 1, DEPTH));

    assign accept  = bus.in_valid && (state_q == ST_OK);
    assign do_push = accept && (bus.opcode == OP_PUSH) && !is_full;
    assign do_pop  = accept && (bus.opcode == OP_POP)  && has1;
    assign do_comb = accept && (bus.opcode == OP_COMB) && has2;

    opq_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .inc1  (do_pop),
        .inc2  (do_comb),
        .ptr   (head)
    );

    opq_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc1  (do_push || do_comb),
        .inc2  (1'b0),
        .ptr   (wr)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        count_d    = count_q;
        mem_d      = mem_q;

        unique case (state_q)
            ST_OK: begin
                if (accept) begin
                    case (bus.opcode)
                        OP_PUSH: if (!is_full) begin
                            state_d = ST_OK;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_OVF;
                        end
                        OP_POP: if (!has1) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_UNF;
                        end
                        OP_COMB: if (!has2) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_COMB;
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
            ST_ERR: begin
                if (bus.err_clr) begin
                    state_d    = ST_OK;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = state_q;
        endcase

        // Free slots before writing: a combine on a full ring reuses the freed head slot.
        if (do_pop || do_comb) mem_d[head]     = '0;
        if (do_comb)           mem_d[head_nxt] = '0;
        if (do_push || do_comb) mem_d[wr]      = bus.din;

        if (do_push)     count_d = count_q + CNT_W'(1);
        else if (do_pop || do_comb) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OK;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

`ifdef OPQ_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (bus.in_valid && (state_q == ST_ERR) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.in_ready = (state_q == ST_OK);
    assign bus.err      = (state_q == ST_ERR);
    assign bus.err_code = err_code_q;
    assign bus.count    = count_q;
    assign bus.empty    = !has1;
    assign bus.full     = is_full;
    assign bus.top_pair = {(has1 ? mem_q[head] : DATA_W'(0)),
                           (has2 ? mem_q[head_nxt] : DATA_W'(0))};
    assign bus.tail     = has1 ? mem_q[wr_prev] : DATA_W'(0);

endmodule
`default_nettype wire

// File: tb/tb_param_op_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_op_queue
// Brief    : Directed vector table, async-reset sequence and randomized run
//            against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_param_op_queue;
    import opq_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 5;

    typedef struct {
        logic        v;
        opcode_e     op;
        logic [7:0]  din;
        logic        clr;
        int          cnt;
        logic [15:0] top;
        logic [7:0]  tail;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    logic [7:0] mq[$];
    logic       m_err;
    logic [1:0] m_code;
    int         m_cnt;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    param_op_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_op_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic vec_t mk(logic v, opcode_e op, logic [7:0] din, logic clr, int cnt,
                                logic [15:0] top, logic [7:0] tail, logic err, logic [1:0] code);
        vec_t r;
        r.v = v; r.op = op; r.din = din; r.clr = clr; r.cnt = cnt;
        r.top = top; r.tail = tail; r.err = err; r.code = code;
        return r;
    endfunction

    task automatic check(input string name, input int cnt, input logic [15:0] top,
                         input logic [7:0] tail, input logic err, input logic [1:0] code);
        logic ok;
        n_vec++;
        ok = (int'(bus.count) == cnt) && (bus.top_pair == top) && (bus.tail == tail) &&
             (bus.err == err) && (bus.err_code == code) && (bus.in_ready == !err) &&
             (bus.empty == (cnt == 0)) && (bus.full == (cnt == DEPTH));
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d top=%h tail=%h err=%b code=%b rdy=%b empty=%b full=%b; want cnt=%0d top=%h tail=%h err=%b code=%b",
                     name, bus.count, bus.top_pair, bus.tail, bus.err, bus.err_code,
                     bus.in_ready, bus.empty, bus.full, cnt, top, tail, err, code);
        end
    endtask

    task automatic apply(input logic v, input opcode_e op, input logic [7:0] din, input logic clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.din      = din;
        bus.err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_err  = 1'b0;
        m_code = ERR_NONE;
        m_cnt  = 0;
    endtask

    // Reference: the queue contents as a list; errors freeze everything until cleared.
    task automatic model_step(input logic v, input opcode_e op, input logic [7:0] din, input logic clr);
        if (clr) m_cnt = 0;
        else if (v && m_err && m_cnt < 255) m_cnt++;
        if (m_err) begin
            if (clr) begin
                m_err  = 1'b0;
                m_code = ERR_NONE;
            end
        end else if (v) begin
            case (op)
                OP_PUSH: if (mq.size() < DEPTH) mq.push_back(din);
                         else begin m_err = 1'b1; m_code = ERR_OVF; end
                OP_POP:  if (mq.size() >= 1) void'(mq.pop_front());
                         else begin m_err = 1'b1; m_code = ERR_UNF; end
                OP_COMB: if (mq.size() >= 2) begin
                             void'(mq.pop_front());
                             void'(mq.pop_front());
                             mq.push_back(din);
                         end else begin m_err = 1'b1; m_code = ERR_COMB; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] m_top();
        logic [7:0] hi, lo;
        hi = (mq.size() >= 1) ? mq[0] : 8'h00;
        lo = (mq.size() >= 2) ? mq[1] : 8'h00;
        return {hi, lo};
    endfunction

    function automatic logic [7:0] m_tail();
        return (mq.size() >= 1) ? mq[mq.size()-1] : 8'h00;
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.opcode   = OP_NOP;
        bus.din      = '0;
        bus.err_clr  = 1'b0;
        do_reset();
        #1;
        check("reset", 0, 16'h0000, 8'h00, 1'b0, ERR_NONE);

        tbl.push_back(mk(1, OP_PUSH, 8'h11, 0, 1, 16'h1100, 8'h11, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h22, 0, 2, 16'h1122, 8'h22, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h33, 0, 3, 16'h1122, 8'h33, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_COMB, 8'h44, 0, 2, 16'h3344, 8'h44, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h55, 0, 3, 16'h3344, 8'h55, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h66, 0, 4, 16'h3344, 8'h66, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h77, 0, 5, 16'h3344, 8'h77, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h99, 0, 5, 16'h3344, 8'h77, 1, ERR_OVF));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 5, 16'h3344, 8'h77, 1, ERR_OVF));
        tbl.push_back(mk(1, OP_POP,  8'h00, 1, 5, 16'h3344, 8'h77, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 4, 16'h4455, 8'h77, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h88, 0, 5, 16'h4455, 8'h88, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_COMB, 8'hAB, 0, 4, 16'h6677, 8'hAB, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_NOP,  8'hEE, 0, 4, 16'h6677, 8'hAB, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 3, 16'h7788, 8'hAB, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 2, 16'h88AB, 8'hAB, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 1, 16'hAB00, 8'hAB, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 0, 16'h0000, 8'h00, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_POP,  8'h00, 0, 0, 16'h0000, 8'h00, 1, ERR_UNF));
        tbl.push_back(mk(0, OP_NOP,  8'h00, 1, 0, 16'h0000, 8'h00, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h5A, 0, 1, 16'h5A00, 8'h5A, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_COMB, 8'hCC, 0, 1, 16'h5A00, 8'h5A, 1, ERR_COMB));
        tbl.push_back(mk(0, OP_NOP,  8'h00, 1, 1, 16'h5A00, 8'h5A, 0, ERR_NONE));
        tbl.push_back(mk(1, OP_PUSH, 8'h6B, 1, 2, 16'h5A6B, 8'h6B, 0, ERR_NONE));

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].op, tbl[i].din, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].tail,
                  tbl[i].err, tbl[i].code);
        end

        // Asynchronous reset in the middle of a pending push.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_PUSH;
        bus.din      = 8'h7E;
        bus.err_clr  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 16'h0000, 8'h00, 1'b0, ERR_NONE);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 0, 16'h0000, 8'h00, 1'b0, ERR_NONE);

`ifdef OPQ_ERR_COUNT_EN
        do_reset();
        apply(1, OP_POP, 8'h00, 0);
        for (int k = 0; k < 3; k++) apply(1, OP_PUSH, 8'h01, 0);
        n_vec++;
        if (bus.err_cnt != 8'd3) begin
            n_fail++;
            $display("FAIL err_cnt: got %0d want 3", bus.err_cnt);
        end
        apply(0, OP_NOP, 8'h00, 1);
        n_vec++;
        if (bus.err_cnt != 8'd0) begin
            n_fail++;
            $display("FAIL err_cnt_clr: got %0d want 0", bus.err_cnt);
        end
`endif

        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic    v, clr;
            opcode_e op;
            logic [7:0] d;
            v   = ($urandom_range(0, 9) < 8);
            op  = opcode_e'(2'($urandom_range(0, 3)));
            d   = 8'($urandom);
            clr = ($urandom_range(0, 4) == 0);
            apply(v, op, d, clr);
            model_step(v, op, d, clr);
            check($sformatf("rand%0d", k), mq.size(), m_top(), m_tail(), m_err, m_code);
`ifdef OPQ_ERR_COUNT_EN
            n_vec++;
            if (int'(bus.err_cnt) != m_cnt) begin
                n_fail++;
                $display("FAIL rand_err_cnt%0d: got %0d want %0d", k, bus.err_cnt, m_cnt);
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
